// File: rtl/inverse_cdf_fold_lanes.sv
// Multi-lane fold front end of the inverse-normal-CDF pipeline.
// Each unsigned fixed-point sample u is folded into x in (0, HALF] with a
// negate flag (upper half of the distribution), a tail-region flag and a
// clamp flag (u outside (0, ONE) forced to one LSB). A two-entry skid buffer
// keeps full throughput while ready_out comes straight from a flop.
module inverse_cdf_fold_lanes #(
   parameter int          WIDTH     = 32,
   parameter int          QFRAC     = 16,
   parameter int          LANES     = 4,
   parameter int unsigned P_LOW     = 32'h0000_063A,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   output logic                     ready_out,
   input  logic [LANES*WIDTH-1:0]   u,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic [LANES*WIDTH-1:0]   x,
   output logic [LANES-1:0]         negate,
   output logic [LANES-1:0]         tail,
   output logic [LANES-1:0]         clamp,
   output logic [CNT_WIDTH-1:0]     clamp_cnt
);

   localparam logic [WIDTH-1:0] ONE    = WIDTH'(1) << QFRAC;
   localparam logic [WIDTH-1:0] HALF   = WIDTH'(1) << (QFRAC - 1);
   localparam logic [WIDTH-1:0] PLOW_W = WIDTH'(P_LOW);

   // Number of set bits in a lane flag vector, widened to the counter width.
   function automatic logic [CNT_WIDTH-1:0] popcount(input logic [LANES-1:0] v);
      logic [CNT_WIDTH-1:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + CNT_WIDTH'(v[i]);
      end
      return n;
   endfunction

   // Add that pins at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
   endfunction

   // Fold result of the vector currently on the input port.
   logic [LANES*WIDTH-1:0] fx;
   logic [LANES-1:0]       fneg, ftail, fclamp;

   // Main (output) entry and skid entry of the buffer.
   logic                   vld_q, vld_d;
   logic [LANES*WIDTH-1:0] x_q, x_d;
   logic [LANES-1:0]       neg_q, neg_d, tail_q, tail_d, clamp_q, clamp_d;
   logic                   skid_vld_q, skid_vld_d;
   logic [LANES*WIDTH-1:0] skid_x_q, skid_x_d;
   logic [LANES-1:0]       skid_neg_q, skid_neg_d, skid_tail_q, skid_tail_d;
   logic [LANES-1:0]       skid_clamp_q, skid_clamp_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic accept, consume;

   assign ready_out = ~skid_vld_q;
   assign accept    = valid_in & ready_out;
   assign consume   = vld_q & ready_in;

   assign valid_out = vld_q;
   assign x         = x_q;
   assign negate    = neg_q;
   assign tail      = tail_q;
   assign clamp     = clamp_q;
   assign clamp_cnt = cnt_q;

   // Per-lane fold: mirror the upper half onto (0, HALF], clamp out-of-range inputs.
   always_comb begin
      logic [WIDTH-1:0] lane_u;
      logic [WIDTH-1:0] lane_x;
      fx     = '0;
      fneg   = '0;
      ftail  = '0;
      fclamp = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_u = u[i*WIDTH +: WIDTH];
         lane_x = lane_u;
         if (lane_u == '0) begin
            lane_x    = WIDTH'(1);
            fclamp[i] = 1'b1;
         end else if (lane_u < HALF) begin
            lane_x = lane_u;
         end else if (lane_u < ONE) begin
            lane_x  = ONE - lane_u;
            fneg[i] = 1'b1;
         end else begin
            lane_x    = WIDTH'(1);
            fneg[i]   = 1'b1;
            fclamp[i] = 1'b1;
         end
         fx[i*WIDTH +: WIDTH] = lane_x;
         ftail[i]             = (lane_x < PLOW_W);
      end
   end

   // Skid-buffer next state: fill main when it frees up, park in skid on stall.
   always_comb begin
      vld_d        = vld_q;
      x_d          = x_q;
      neg_d        = neg_q;
      tail_d       = tail_q;
      clamp_d      = clamp_q;
      skid_vld_d   = skid_vld_q;
      skid_x_d     = skid_x_q;
      skid_neg_d   = skid_neg_q;
      skid_tail_d  = skid_tail_q;
      skid_clamp_d = skid_clamp_q;
      cnt_d        = cnt_q;

      if (skid_vld_q) begin
         // No acceptance possible while skid is full; drain it into main.
         if (consume) begin
            x_d        = skid_x_q;
            neg_d      = skid_neg_q;
            tail_d     = skid_tail_q;
            clamp_d    = skid_clamp_q;
            vld_d      = 1'b1;
            skid_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (!vld_q || ready_in) begin
            x_d     = fx;
            neg_d   = fneg;
            tail_d  = ftail;
            clamp_d = fclamp;
            vld_d   = 1'b1;
         end else begin
            skid_x_d     = fx;
            skid_neg_d   = fneg;
            skid_tail_d  = ftail;
            skid_clamp_d = fclamp;
            skid_vld_d   = 1'b1;
         end
      end else if (consume) begin
         vld_d = 1'b0;
      end

      if (accept) begin
         cnt_d = sat_add(cnt_q, popcount(fclamp));
      end
   end

   // State registers; reset empties both entries and clears the counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q        <= 1'b0;
         x_q          <= '0;
         neg_q        <= '0;
         tail_q       <= '0;
         clamp_q      <= '0;
         skid_vld_q   <= 1'b0;
         skid_x_q     <= '0;
         skid_neg_q   <= '0;
         skid_tail_q  <= '0;
         skid_clamp_q <= '0;
         cnt_q        <= '0;
      end else begin
         vld_q        <= vld_d;
         x_q          <= x_d;
         neg_q        <= neg_d;
         tail_q       <= tail_d;
         clamp_q      <= clamp_d;
         skid_vld_q   <= skid_vld_d;
         skid_x_q     <= skid_x_d;
         skid_neg_q   <= skid_neg_d;
         skid_tail_q  <= skid_tail_d;
         skid_clamp_q <= skid_clamp_d;
         cnt_q        <= cnt_d;
      end
   end

   // Upstream must hold a stalled vector; this block must hold a stalled output.
   a_in_hold: assert property (@(posedge clk) disable iff (rst)
      valid_in && !ready_out |=> $stable(u) && valid_in);
   a_out_hold: assert property (@(posedge clk) disable iff (rst)
      valid_out && !ready_in |=> $stable({x, negate, tail, clamp}));

endmodule

// File: tb/tb_inverse_cdf_fold_lanes.sv
// Directed bench for inverse_cdf_fold_lanes (WIDTH=32, QFRAC=16, LANES=4).
module tb_inverse_cdf_fold_lanes;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_in;
   logic         ready_out;
   logic [127:0] u;
   logic         valid_out;
   logic         ready_in;
   logic [127:0] x;
   logic [3:0]   negate, tail, clamp;
   logic [15:0]  clamp_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   typedef struct packed {
      logic [127:0] x;
      logic [3:0]   n;
      logic [3:0]   t;
      logic [3:0]   c;
   } vec_t;

   vec_t         e;
   vec_t         q[$];
   logic [127:0] va, vb, vc;
   logic [31:0]  lane;

   inverse_cdf_fold_lanes dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .u         (u),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .x         (x),
      .negate    (negate),
      .tail      (tail),
      .clamp     (clamp),
      .clamp_cnt (clamp_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference fold of one vector, written from the mathematical definition.
   function automatic vec_t ref_vec(input logic [127:0] uv);
      vec_t r;
      logic [31:0] v, xo;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         v = uv[i*32 +: 32];
         if (v == 32'd0 || v >= 32'h10000) begin
            xo     = 32'd1;
            r.c[i] = 1'b1;
            r.n[i] = (v != 32'd0);
         end else if (v >= 32'h8000) begin
            xo     = 32'h10000 - v;
            r.n[i] = 1'b1;
         end else begin
            xo = v;
         end
         r.x[i*32 +: 32] = xo;
         r.t[i]          = (xo < 32'h063A);
      end
      return r;
   endfunction

   function automatic int add_cnt(input int c, input vec_t r);
      int s;
      s = c + int'(r.c[0]) + int'(r.c[1]) + int'(r.c[2]) + int'(r.c[3]);
      return (s > 65535) ? 65535 : s;
   endfunction

   task automatic chk_out(input string tag, input vec_t r);
      chk({tag, ".x"}, x, r.x);
      chk({tag, ".negate"}, {124'd0, negate}, {124'd0, r.n});
      chk({tag, ".tail"}, {124'd0, tail}, {124'd0, r.t});
      chk({tag, ".clamp"}, {124'd0, clamp}, {124'd0, r.c});
   endtask

   function automatic logic [31:0] rand_lane();
      logic [31:0] sp [5];
      sp[0] = 32'h0;     sp[1] = 32'h8000; sp[2] = 32'h10000;
      sp[3] = 32'hFFFF;  sp[4] = 32'h1;
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return $urandom_range(0, 32'h1FFFF);
         2:       return sp[$urandom_range(0, 4)];
         default: return $urandom_range(0, 32'hFFFF);
      endcase
   endfunction

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b1;
      u        = '0;
      step();
      step();
      chk("reset.valid_out", {127'd0, valid_out}, 128'd0);
      chk("reset.ready_out", {127'd0, ready_out}, 128'd1);
      chk("reset.clamp_cnt", {112'd0, clamp_cnt}, 128'd0);
      chk("reset.x", x, 128'd0);
      rst = 1'b0;
      step();

      // Basic fold: zero, quarter, half, three-quarter
      valid_in = 1'b1;
      u = {32'hC000, 32'h8000, 32'h4000, 32'h0000};
      step();
      valid_in = 1'b0;
      chk("t1.valid_out", {127'd0, valid_out}, 128'd1);
      e.x = {32'h4000, 32'h8000, 32'h4000, 32'h0001};
      e.n = 4'b1100; e.t = 4'b0001; e.c = 4'b0001;
      chk_out("t1", e);
      chk("t1.clamp_cnt", {112'd0, clamp_cnt}, 128'd1);
      step();
      chk("t1.drain", {127'd0, valid_out}, 128'd0);

      // Out-of-range high inputs clamp with negate
      valid_in = 1'b1;
      u = {32'h7FFF, 32'h0001, 32'hFFFF_FFFF, 32'h0001_0000};
      step();
      valid_in = 1'b0;
      e.x = {32'h7FFF, 32'h0001, 32'h0001, 32'h0001};
      e.n = 4'b0011; e.t = 4'b0111; e.c = 4'b0011;
      chk_out("t2", e);
      chk("t2.clamp_cnt", {112'd0, clamp_cnt}, 128'd3);
      exp_cnt = 3;
      step();

      // Tail threshold boundary and mirrored boundary
      valid_in = 1'b1;
      u = {32'hFFFF, 32'hF9C7, 32'h0639, 32'h063A};
      step();
      valid_in = 1'b0;
      e.x = {32'h0001, 32'h0639, 32'h0639, 32'h063A};
      e.n = 4'b1100; e.t = 4'b1110; e.c = 4'b0000;
      chk_out("t5", e);
      chk("t5.clamp_cnt", {112'd0, clamp_cnt}, 128'd3);
      step();

      // Random streaming at full rate
      for (int i = 0; i < 100; i++) begin
         for (int l = 0; l < 4; l++) begin
            lane = rand_lane();
            u[l*32 +: 32] = lane;
         end
         valid_in = 1'b1;
         e = ref_vec(u);
         q.push_back(e);
         exp_cnt = add_cnt(exp_cnt, e);
         step();
         chk("t3.ready_out", {127'd0, ready_out}, 128'd1);
         chk("t3.valid_out", {127'd0, valid_out}, 128'd1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk_out("t3", e);
         end
      end
      valid_in = 1'b0;
      step();
      chk("t3.drain", {127'd0, valid_out}, 128'd0);
      chk("t3.queue_empty", 128'(q.size()), 128'd0);
      chk("t3.clamp_cnt", {112'd0, clamp_cnt}, 128'(exp_cnt));

      // Counter saturation: all-zero vectors, four clamps each
      valid_in = 1'b1;
      u = '0;
      for (int i = 0; i < 16384; i++) begin
         step();
      end
      valid_in = 1'b0;
      chk("sat.clamp_cnt", {112'd0, clamp_cnt}, 128'hFFFF);
      step();

      // Backpressure through the skid entry
      va = {32'h1234, 32'h9000, 32'h0000, 32'h20000};
      vb = {32'h0100, 32'h0200, 32'h0300, 32'hFFF0};
      vc = {32'h8000, 32'h7FFF, 32'h063A, 32'h0639};
      ready_in = 1'b0;
      valid_in = 1'b1;
      u = va;
      step();
      chk("t4.a_valid", {127'd0, valid_out}, 128'd1);
      chk("t4.a_ready", {127'd0, ready_out}, 128'd1);
      chk_out("t4.a", ref_vec(va));
      u = vb;
      step();
      chk("t4.skid_ready", {127'd0, ready_out}, 128'd0);
      chk_out("t4.a_hold1", ref_vec(va));
      u = vc;
      step();
      step();
      chk("t4.stall_ready", {127'd0, ready_out}, 128'd0);
      chk("t4.stall_valid", {127'd0, valid_out}, 128'd1);
      chk_out("t4.a_hold2", ref_vec(va));
      ready_in = 1'b1;
      step();
      chk("t4.b_valid", {127'd0, valid_out}, 128'd1);
      chk("t4.b_ready", {127'd0, ready_out}, 128'd1);
      chk_out("t4.b", ref_vec(vb));
      step();
      valid_in = 1'b0;
      chk("t4.c_valid", {127'd0, valid_out}, 128'd1);
      chk_out("t4.c", ref_vec(vc));
      step();
      chk("t4.drain", {127'd0, valid_out}, 128'd0);
      chk("t4.sat_hold", {112'd0, clamp_cnt}, 128'hFFFF);

      // Reset with both entries full
      ready_in = 1'b0;
      valid_in = 1'b1;
      u = {32'h0500, 32'h0600, 32'h0700, 32'h0800};
      step();
      u = {32'h0900, 32'h0A00, 32'h0B00, 32'h0C00};
      step();
      valid_in = 1'b0;
      chk("t6.full_ready", {127'd0, ready_out}, 128'd0);
      chk("t6.full_valid", {127'd0, valid_out}, 128'd1);
      rst = 1'b1;
      #1;
      chk("t6.rst_valid", {127'd0, valid_out}, 128'd0);
      chk("t6.rst_ready", {127'd0, ready_out}, 128'd1);
      chk("t6.rst_cnt", {112'd0, clamp_cnt}, 128'd0);
      chk("t6.rst_x", x, 128'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("t6.idle_valid", {127'd0, valid_out}, 128'd0);
      ready_in = 1'b1;
      valid_in = 1'b1;
      u = {32'hFFFF, 32'h0000, 32'h0200, 32'h0100};
      step();
      valid_in = 1'b0;
      chk("t6.g_valid", {127'd0, valid_out}, 128'd1);
      e.x = {32'h0001, 32'h0001, 32'h0200, 32'h0100};
      e.n = 4'b1000; e.t = 4'b1111; e.c = 4'b0100;
      chk_out("t6.g", e);
      chk("t6.g_cnt", {112'd0, clamp_cnt}, 128'd1);
      step();
      chk("t6.drain", {127'd0, valid_out}, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
